// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// counter sizing helper.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   localparam int WIDTH_DEFAULT = 8;

   // Bits needed to count 0..width-1; never below one bit.
   function automatic int cnt_width(input int width);
      if (width < 2) begin
         return 1;
      end else begin
         return $clog2(width);
      end
   endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// Purely combinational 1-bit full subtractor: diff = x - y - bi, bo = borrow out.
module full_sub (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic diff,
   output logic bo
);

   assign diff = x ^ y ^ bi;
   assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor {bout, d} = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             busy,
   output logic             done
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [WIDTH-1:0] rd_q, rd_d;
   logic             br_q, br_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             x_s;
   logic             nb_s;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   full_sub u_full_sub (
      .x    (ra_q[0]),
      .y    (rb_q[0]),
      .bi   (br_q),
      .diff (x_s),
      .bo   (nb_s)
   );

   // Next-state, datapath shifting and result capture.
   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rd_d    = rd_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               br_d    = bin;
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            ra_d = {1'b0, ra_q[WIDTH-1:1]};
            rb_d = {1'b0, rb_q[WIDTH-1:1]};
            rd_d = {x_s, rd_q[WIDTH-1:1]};
            br_d = nb_s;
            if (cnt_q == CNT_LAST) begin
               d_d     = {x_s, rd_q[WIDTH-1:1]};
               bout_d  = nb_s;
`ifdef SERIAL_SUB_OVF_EN
               // br_q is the borrow into the MSB, nb_s the borrow out of it.
               ovf_d   = br_q ^ nb_s;
`endif
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_SHIFT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_SHIFT);
      done_d = (state_d == S_DONE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ra_q    <= {WIDTH{1'b0}};
         rb_q    <= {WIDTH{1'b0}};
         rd_q    <= {WIDTH{1'b0}};
         br_q    <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
         d_q     <= {WIDTH{1'b0}};
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rd_q    <= rd_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign d    = d_q;
   assign bout = bout_q;
   assign busy = busy_q;
   assign done = done_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed handshake scenarios plus random
// operands checked against an arithmetic model of a - b - bin.
module tb_serial_sub;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic [W-1:0] d;
   logic         bout;
   logic         busy;
   logic         done;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int total = 0;
   int bad   = 0;

   logic [W-1:0] ref_a, ref_b;
   logic         ref_bin;
   logic [W-1:0] prev_d;
   logic         prev_bout;

   serial_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .d     (d),
      .bout  (bout),
      .busy  (busy),
      .done  (done)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT in IDLE or DONE; leaves us at the
   // negedge just after the accepting edge.
   task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
      a = av; b = bv; bin = bi; start = 1'b1;
      ref_a = av; ref_b = bv; ref_bin = bi;
      @(negedge clk);
      start = 1'b0;
      a   = W'($urandom());
      b   = W'($urandom());
      bin = 1'($urandom());
      chk("busy_on_accept", {31'd0, busy}, 32'd1);
      chk("d_hold_on_start", {24'd0, d}, {24'd0, prev_d});
      chk("bout_hold_on_start", {31'd0, bout}, {31'd0, prev_bout});
   endtask

   // Waits (bounded) for done and checks latency, busy length and result.
   // poke >= 0 fires an extra start with a=all-ones, b=0 at that cycle.
   task automatic wait_result(input string tag, input int poke);
      int cyc;
      int busy_cnt;
      logic [W:0] exp;
      int sa, sb, sr;
      logic exp_ovf;
      exp = {1'b0, ref_a} - {1'b0, ref_b} - {{W{1'b0}}, ref_bin};
      sa = $signed(ref_a);
      sb = $signed(ref_b);
      sr = sa - sb - int'(ref_bin);
      exp_ovf = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
      cyc = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && cyc < 3 * W) begin
         if (busy === 1'b1) busy_cnt++;
         if (cyc == poke) begin
            start = 1'b1; a = {W{1'b1}}; b = {W{1'b0}}; bin = 1'b0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, cyc, W);
      chk({tag, "_busy_len"}, busy_cnt, W);
      chk({tag, "_d"}, {24'd0, d}, {24'd0, exp[W-1:0]});
      chk({tag, "_bout"}, {31'd0, bout}, {31'd0, exp[W]});
      chk({tag, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`else
      if (exp_ovf === 1'bx) $display("note: unknown overflow model value");
`endif
      prev_d    = exp[W-1:0];
      prev_bout = exp[W];
   endtask

   task automatic idle_after(input string tag);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
      chk({tag, "_idle_not_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int extra_done;
      int extra_busy;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      prev_d = '0; prev_bout = 1'b0;
      ref_a = '0; ref_b = '0; ref_bin = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_d", {24'd0, d}, 32'd0);
      chk("reset_bout", {31'd0, bout}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      chk("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      launch(8'd10, 8'd6, 1'b0);
      wait_result("basic", -1);
      idle_after("basic");

      launch(8'd4, 8'd6, 1'b0);
      wait_result("borrow", -1);
      idle_after("borrow");
      launch(8'd0, 8'd0, 1'b1);
      wait_result("borrow_bin", -1);
      idle_after("borrow_bin");

      // Extra start mid-operation must neither alter nor extend the operation.
      launch(8'h33, 8'h11, 1'b0);
      wait_result("ignored_start", 2);
      extra_done = 0;
      extra_busy = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         if (done === 1'b1) extra_done++;
         if (busy === 1'b1) extra_busy++;
      end
      chk("ignored_start_no_extra_done", extra_done, 0);
      chk("ignored_start_no_extra_busy", extra_busy, 0);

      // Back-to-back: next start presented while done is high.
      launch(8'd4, 8'd6, 1'b0);
      wait_result("b2b_first", -1);
      launch(8'd200, 8'd55, 1'b0);
      wait_result("b2b_second", -1);
      idle_after("b2b_second");

      // Reset five cycles into an operation.
      launch(8'd100, 8'd1, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_d", {24'd0, d}, 32'd0);
      chk("midrst_bout", {31'd0, bout}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      prev_d = '0;
      prev_bout = 1'b0;
      @(negedge clk);
      chk("midrst_no_done_after", {31'd0, done}, 32'd0);
      launch(8'd10, 8'd6, 1'b0);
      wait_result("after_rst", -1);
      idle_after("after_rst");

      launch(8'h80, 8'h01, 1'b0);
      wait_result("ovf_case1", -1);
      idle_after("ovf_case1");
      launch(8'h05, 8'h03, 1'b0);
      wait_result("ovf_case2", -1);
      idle_after("ovf_case2");

      // Random operands, alternating idle gaps and back-to-back chaining.
      for (int n = 0; n < 24; n++) begin
         launch(W'($urandom()), W'($urandom()), 1'($urandom()));
         wait_result("rand", -1);
         if (n % 2 == 0) idle_after("rand");
      end
      idle_after("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
